// File: rtl/isa_core_fsm.sv
// isa_core_fsm: multi-cycle FETCH/DECODE/EXEC/HALT instruction-set core with condition-code PSR.
// Define DIV_EN to enable the DIV/RMD opcodes; otherwise they decode as illegal NOPs.
module isa_core_fsm #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MAXREGS  = 16,
    parameter int SBITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDRSIZE-1:0]   INS_ADDR,
    input  logic [2*ADDRSIZE+7:0] INS_MEM,
    output logic [ADDRSIZE-1:0]   MEM_ADDR,
    input  logic [WIDTH-1:0]      MEM_IN,
    output logic [WIDTH-1:0]      MEM_OUT,
    output logic                  MEM_CTRL,
    output logic                  halted,
    output logic                  illegal,
    output logic [1:0]            debuger,
    output logic [SBITS-1:0]      psr_out
);
    localparam int IW   = 2*ADDRSIZE + 8;
    localparam int RIDX = $clog2(MAXREGS);

    localparam logic [3:0] OP_NOP = 4'd0, OP_BRA = 4'd1, OP_LD  = 4'd2, OP_STR = 4'd3,
                           OP_ADD = 4'd4, OP_MUL = 4'd5, OP_CMP = 4'd6, OP_SHF = 4'd7,
                           OP_ROT = 4'd8, OP_HLT = 4'd9, OP_DIV = 4'd10, OP_RMD = 4'd11;
    localparam int P_CARRY = 0, P_EVEN = 1, P_PARITY = 2, P_ZERO = 3, P_NEG = 4;

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_DECODE = 2'd1, S_EXEC = 2'd2, S_HALT = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [IW-1:0]       ir_q, ir_d;
    logic [SBITS-1:0]    psr_q, psr_d;
    logic [WIDTH-1:0]    rfile_q [MAXREGS];
    logic [WIDTH-1:0]    rfile_d [MAXREGS];
    logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_out_q, mem_out_d;
    logic                mem_ctrl_q, mem_ctrl_d;
    logic                illegal_q, illegal_d;

    // Decode-side view of the incoming word: LD address and STR data are set up a cycle early
    logic [3:0]          dec_op;
    logic                dec_srct;
    logic [ADDRSIZE-1:0] dec_src, dec_dst;
    logic [WIDTH-1:0]    dec_src_val;

    assign dec_op      = INS_MEM[IW-1 -: 4];
    assign dec_srct    = INS_MEM[IW-5];
    assign dec_src     = INS_MEM[2*ADDRSIZE-1 -: ADDRSIZE];
    assign dec_dst     = INS_MEM[ADDRSIZE-1:0];
    assign dec_src_val = dec_srct ? WIDTH'(dec_src) : rfile_q[dec_src[RIDX-1:0]];

    logic [3:0]          op, cc;
    logic [ADDRSIZE-1:0] src_f, dst_f;
    logic [WIDTH-1:0]    src_val, dst_val;

    assign op      = ir_q[IW-1 -: 4];
    assign cc      = ir_q[IW-5 -: 4];
    assign src_f   = ir_q[2*ADDRSIZE-1 -: ADDRSIZE];
    assign dst_f   = ir_q[ADDRSIZE-1:0];
    assign src_val = cc[3] ? WIDTH'(src_f) : rfile_q[src_f[RIDX-1:0]];
    assign dst_val = rfile_q[dst_f[RIDX-1:0]];

    // Shift/rotate count is the raw SRC field read as signed; negative means left
    logic [ADDRSIZE:0] cnt_x, mag;
    logic              shl;
    int                rot_k;
    logic [WIDTH-1:0]  shf_val, rot_val;
    logic [WIDTH:0]    add_res, cmp_res, mul_res;

    assign shl     = src_f[ADDRSIZE-1];
    assign cnt_x   = {src_f[ADDRSIZE-1], src_f};
    assign mag     = shl ? (~cnt_x + (ADDRSIZE+1)'(1)) : cnt_x;
    assign rot_k   = int'(mag) % WIDTH;
    assign add_res = {1'b0, dst_val} + {1'b0, src_val};
    assign cmp_res = {1'b0, dst_val} - {1'b0, src_val};
    assign mul_res = (WIDTH+1)'(dst_val) * (WIDTH+1)'(src_val);

    always_comb begin
        shf_val = '0;
        if (32'(mag) < WIDTH)
            shf_val = shl ? (dst_val << mag) : (dst_val >> mag);
        rot_val = shl ? ((dst_val << rot_k) | (dst_val >> (WIDTH - rot_k)))
                      : ((dst_val >> rot_k) | (dst_val << (WIDTH - rot_k)));
    end

    logic [WIDTH:0]   res;
    logic [WIDTH-1:0] wdata;
    logic             rf_wr, psr_wr, taken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        psr_d      = psr_q;
        rfile_d    = rfile_q;
        mem_addr_d = mem_addr_q;
        mem_out_d  = mem_out_q;
        mem_ctrl_d = 1'b0;
        illegal_d  = 1'b0;
        res        = '0;
        wdata      = '0;
        rf_wr      = 1'b0;
        psr_wr     = 1'b0;
        taken      = 1'b0;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = INS_MEM;
                pc_d    = pc_q + ADDRSIZE'(1);
                state_d = S_EXEC;
                if (dec_op == OP_LD && !dec_srct)
                    mem_addr_d = dec_src;
                if (dec_op == OP_STR) begin
                    mem_addr_d = dec_dst;
                    mem_out_d  = dec_src_val;
                    mem_ctrl_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_NOP: ;
                    OP_BRA: begin
                        case (cc)
                            4'd0:    taken = 1'b1;
                            4'd1:    taken = psr_q[P_CARRY];
                            4'd2:    taken = psr_q[P_EVEN];
                            4'd3:    taken = psr_q[P_PARITY];
                            4'd4:    taken = psr_q[P_ZERO];
                            4'd5:    taken = psr_q[P_NEG];
                            default: illegal_d = 1'b1;
                        endcase
                        if (taken) pc_d = dst_f;
                    end
                    OP_LD: begin
                        wdata = cc[3] ? WIDTH'(src_f) : MEM_IN;
                        res   = {1'b0, wdata};
                        rf_wr = 1'b1; psr_wr = 1'b1;
                    end
                    OP_STR: begin
                        res    = {1'b0, src_val};
                        psr_wr = 1'b1;
                    end
                    OP_ADD: begin res = add_res; wdata = add_res[WIDTH-1:0]; rf_wr = 1'b1; psr_wr = 1'b1; end
                    OP_MUL: begin res = mul_res; wdata = mul_res[WIDTH-1:0]; rf_wr = 1'b1; psr_wr = 1'b1; end
                    OP_CMP: begin res = cmp_res; psr_wr = 1'b1; end
                    OP_SHF: begin res = {1'b0, shf_val}; wdata = shf_val; rf_wr = 1'b1; psr_wr = 1'b1; end
                    OP_ROT: begin res = {1'b0, rot_val}; wdata = rot_val; rf_wr = 1'b1; psr_wr = 1'b1; end
                    OP_HLT: state_d = S_HALT;
`ifdef DIV_EN
                    OP_DIV, OP_RMD: begin
                        psr_wr = 1'b1;
                        if (src_val == '0) begin
                            // Divide by zero keeps the destination and flags CARRY
                            res       = {1'b1, dst_val};
                            illegal_d = 1'b1;
                        end else begin
                            wdata = (op == OP_DIV) ? (dst_val / src_val) : (dst_val % src_val);
                            res   = {1'b0, wdata};
                            rf_wr = 1'b1;
                        end
                    end
`endif
                    default: illegal_d = 1'b1;
                endcase
                if (rf_wr) rfile_d[dst_f[RIDX-1:0]] = wdata;
                if (psr_wr) begin
                    psr_d[P_CARRY]  = res[WIDTH];
                    psr_d[P_EVEN]   = ~res[0];
                    psr_d[P_PARITY] = ^res;
                    psr_d[P_ZERO]   = ~|res;
                    psr_d[P_NEG]    = res[WIDTH-1];
                end
            end
            S_HALT: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            psr_q      <= '0;
            mem_addr_q <= '0;
            mem_out_q  <= '0;
            mem_ctrl_q <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < MAXREGS; i++) rfile_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            psr_q      <= psr_d;
            mem_addr_q <= mem_addr_d;
            mem_out_q  <= mem_out_d;
            mem_ctrl_q <= mem_ctrl_d;
            illegal_q  <= illegal_d;
            rfile_q    <= rfile_d;
        end
    end

    assign INS_ADDR = pc_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_OUT  = mem_out_q;
    assign MEM_CTRL = mem_ctrl_q;
    assign illegal  = illegal_q;
    assign halted   = (state_q == S_HALT);
    assign debuger  = state_q;
    assign psr_out  = psr_q;

endmodule

// File: tb/tb_isa_core_fsm.sv
// tb_isa_core_fsm: directed plus randomized instruction stream against an
// instruction-level reference model of the core.
module tb_isa_core_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] INS_ADDR, MEM_ADDR;
    logic [31:0] INS_MEM = '0, MEM_IN = '0, MEM_OUT;
    logic        MEM_CTRL, halted, illegal;
    logic [1:0]  debuger;
    logic [4:0]  psr_out;

    isa_core_fsm #(.WIDTH(32), .ADDRSIZE(12), .MAXREGS(16), .SBITS(5)) dut (
        .clk(clk), .rst(rst), .INS_ADDR(INS_ADDR), .INS_MEM(INS_MEM),
        .MEM_ADDR(MEM_ADDR), .MEM_IN(MEM_IN), .MEM_OUT(MEM_OUT), .MEM_CTRL(MEM_CTRL),
        .halted(halted), .illegal(illegal), .debuger(debuger), .psr_out(psr_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    logic [11:0] m_pc;
    logic [31:0] m_rf [16];
    logic [4:0]  m_psr;
    logic        m_ill;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] nib,
                                       input logic [11:0] s, input logic [11:0] d);
        return {op, nib, s, d};
    endfunction

    // Flags {NEG, ZERO, PARITY, EVEN, CARRY} of a 33-bit result
    function automatic logic [4:0] flags(input logic [32:0] r);
        return {r[31], r == 33'd0, ^r, ~r[0], r[32]};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_psr = '0; m_ill = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic [31:0] min);
        logic [3:0]  op, nib;
        logic [11:0] s, d;
        logic [31:0] sv, dv, r;
        logic [63:0] w;
        int c, n;
        op = ins[31:28]; nib = ins[27:24]; s = ins[23:12]; d = ins[11:0];
        sv = nib[3] ? {20'd0, s} : m_rf[s[3:0]];
        dv = m_rf[d[3:0]];
        m_pc  = m_pc + 12'd1;
        m_ill = 1'b0;
        case (op)
            4'd0, 4'd9: ;
            4'd1: if (nib > 4'd5) m_ill = 1'b1;
                  else if (nib == 4'd0 || m_psr[nib - 4'd1]) m_pc = d;
            4'd2: begin r = nib[3] ? {20'd0, s} : min; m_rf[d[3:0]] = r; m_psr = flags({1'b0, r}); end
            4'd3: m_psr = flags({1'b0, sv});
            4'd4: begin w = {32'd0, dv} + {32'd0, sv}; m_rf[d[3:0]] = w[31:0]; m_psr = flags(w[32:0]); end
            4'd5: begin w = {32'd0, dv} * {32'd0, sv}; m_rf[d[3:0]] = w[31:0]; m_psr = flags(w[32:0]); end
            4'd6: begin w = {32'd0, dv} - {32'd0, sv}; m_psr = flags(w[32:0]); end
            4'd7, 4'd8: begin
                c = s[11] ? int'(s) - 4096 : int'(s);
                n = (c < 0) ? -c : c;
                if (op == 4'd7) r = (n >= 32) ? 32'd0 : ((c < 0) ? (dv << n) : (dv >> n));
                else begin
                    r = dv;
                    repeat (n % 32) r = (c < 0) ? {r[30:0], r[31]} : {r[0], r[31:1]};
                end
                m_rf[d[3:0]] = r; m_psr = flags({1'b0, r});
            end
`ifdef DIV_EN
            4'd10, 4'd11: begin
                if (sv == 32'd0) begin m_ill = 1'b1; m_psr = flags({1'b1, dv}); end
                else begin
                    r = (op == 4'd10) ? dv / sv : dv % sv;
                    m_rf[d[3:0]] = r; m_psr = flags({1'b0, r});
                end
            end
`endif
            default: m_ill = 1'b1;
        endcase
    endtask

    // Entered #1 after the edge that puts the core in FETCH; leaves at the same point
    task automatic run(input logic [31:0] ins, input logic [31:0] min);
        logic [31:0] sv;
        sv = ins[27] ? {20'd0, ins[23:12]} : m_rf[ins[15:12]];
        check("fetch_state", debuger, 2'd0);
        check("ins_addr", INS_ADDR, m_pc);
        check("illegal", illegal, m_ill);
        check("psr", psr_out, m_psr);
        check("mem_ctrl_fetch", MEM_CTRL, 1'b0);
        INS_MEM = ins; MEM_IN = min;
        @(posedge clk); #1;
        check("decode_state", debuger, 2'd1);
        check("mem_ctrl_decode", MEM_CTRL, 1'b0);
        @(posedge clk); #1;
        check("exec_state", debuger, 2'd2);
        if (ins[31:28] == 4'd3) begin
            check("str_ctrl", MEM_CTRL, 1'b1);
            check("str_addr", MEM_ADDR, ins[11:0]);
            check("str_data", MEM_OUT, sv);
        end else check("mem_ctrl_exec", MEM_CTRL, 1'b0);
        if (ins[31:28] == 4'd2 && !ins[27]) check("ld_addr", MEM_ADDR, ins[23:12]);
        model_step(ins, min);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        INS_MEM = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ins_addr", INS_ADDR, 12'd0);
        check("rst_mem_addr", MEM_ADDR, 12'd0);
        check("rst_mem_out", MEM_OUT, 32'd0);
        check("rst_mem_ctrl", MEM_CTRL, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_debuger", debuger, 2'd0);
        check("rst_psr", psr_out, 5'd0);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0]  op;
        logic [11:0] s;
        logic [31:0] min;

        do_reset();
        repeat (3) run(mk(4'd0, 4'd0, 12'd0, 12'd0), 32'd0);
        check("pc_after_nops", INS_ADDR, 12'd3);

        // Load / add / carry-out
        run(mk(4'd2, 4'h8, 12'h0FF, 12'd1), 32'd0);
        run(mk(4'd4, 4'h8, 12'd1, 12'd1), 32'd0);
        check("add256_psr", psr_out, 5'b00110);
        run(mk(4'd2, 4'h0, 12'h123, 12'd2), 32'hFFFF_FFFF);
        run(mk(4'd4, 4'h8, 12'd1, 12'd2), 32'd0);
        check("add_wrap_psr", psr_out, 5'b00111);

        // Store / load through memory
        run(mk(4'd3, 4'h0, 12'd1, 12'h010), 32'd0);
        check("str_once", MEM_CTRL, 1'b0);
        run(mk(4'd2, 4'h0, 12'd16, 12'd3), 32'd256);
        run(mk(4'd3, 4'h0, 12'd3, 12'd5), 32'd0);

        // Compare and branches
        run(mk(4'd6, 4'h8, 12'd256, 12'd1), 32'd0);
        check("cmp_zero_psr", psr_out, 5'b01010);
        run(mk(4'd1, 4'd4, 12'd0, 12'h020), 32'd0);
        check("bra_taken", INS_ADDR, 12'h020);
        run(mk(4'd1, 4'd1, 12'd0, 12'h100), 32'd0);
        check("bra_fallthru", INS_ADDR, 12'h021);
        run(mk(4'd3, 4'h0, 12'd1, 12'd0), 32'd0);

        // Shifts and rotates
        run(mk(4'd2, 4'h8, 12'd1, 12'd4), 32'd0);
        run(mk(4'd7, 4'h0, 12'hFFC, 12'd4), 32'd0);
        run(mk(4'd3, 4'h0, 12'd4, 12'd0), 32'd0);
        run(mk(4'd7, 4'h0, 12'd40, 12'd4), 32'd0);
        check("shf_big_psr", psr_out, 5'b01010);
        run(mk(4'd2, 4'h0, 12'd0, 12'd5), 32'h8000_0001);
        run(mk(4'd8, 4'h0, 12'd1, 12'd5), 32'd0);
        run(mk(4'd3, 4'h0, 12'd5, 12'd0), 32'd0);

        // Illegal encodings
        run(mk(4'd13, 4'h0, 12'd0, 12'd0), 32'd0);
        check("illegal_op", illegal, 1'b1);
        run(mk(4'd1, 4'd7, 12'd0, 12'h300), 32'd0);
        check("illegal_cc", illegal, 1'b1);

        // Randomized stream, HLT excluded
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd9) op = 4'd0;
            s = 12'($urandom);
            if (op == 4'd7 || op == 4'd8) s = 12'($urandom_range(0, 80)) - 12'd40;
            case ($urandom_range(0, 3))
                0:       min = 32'd0;
                1:       min = 32'hFFFF_FFFF;
                default: min = $urandom;
            endcase
            run(mk(op, 4'($urandom), s, 12'($urandom)), min);
        end

        // Halt holds until reset
        run(mk(4'd9, 4'h0, 12'd0, 12'd0), 32'd0);
        check("halt_flag", halted, 1'b1);
        check("halt_state", debuger, 2'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("halt_ins_addr", INS_ADDR, m_pc);
            check("halt_mem_ctrl", MEM_CTRL, 1'b0);
        end

        // Reset landing in the middle of a store
        do_reset();
        run(mk(4'd2, 4'h8, 12'h055, 12'd1), 32'd0);
        INS_MEM = mk(4'd3, 4'h0, 12'd1, 12'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_str_ctrl", MEM_CTRL, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ctrl", MEM_CTRL, 1'b0);
        check("mid_rst_pc", INS_ADDR, 12'd0);
        check("mid_rst_state", debuger, 2'd0);
        rst = 1'b1;
        model_reset();
        run(mk(4'd3, 4'h0, 12'd1, 12'd9), 32'd0);
        run(mk(4'd0, 4'h0, 12'd0, 12'd0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
